// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide unit and the auxiliary decoder that
// drives it.
package muldiv_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_CNT_W = 6;

  localparam logic [1:0] MD_MULTU = 2'b00;
  localparam logic [1:0] MD_DIVU  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10
  } md_state_e;

  function automatic logic md_op_valid(input logic [1:0] op);
    return (op == MD_MULTU) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Decoder/regfile-facing bundle of the multiply/divide unit, plus the FSM state
// exported for observation.
interface muldiv_if
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
);

  // Handshake: we_muldiv is a one-cycle request sampled on the rising edge. It
  // is taken only while busy is low and muldiv_ctrl is a defined op; there is
  // no separate ready, so a request made while busy (or with a reserved code)
  // is dropped, never queued. done pulses for one cycle when HI/LO update.
  logic             we_muldiv;
  logic [1:0]       muldiv_ctrl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hilo_stream;
  logic [WIDTH-1:0] hilo_rd;
  logic             busy;
  logic             done;
  md_state_e        state;

  modport master (
    output we_muldiv, muldiv_ctrl, a, b, hilo_stream,
    input  hilo_rd, busy, done, state
  );

  modport slave (
    input  we_muldiv, muldiv_ctrl, a, b, hilo_stream,
    output hilo_rd, busy, done, state
  );

endinterface

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: a shift-add multiply step or a
// restoring divide step on the 2*WIDTH-bit shadow accumulator.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic               div_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   mcand_i,
  input  logic [WIDTH-1:0]   divisor_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] div_next;

  // Multiply: acc = {partial product high, unconsumed multiplier bits}; the
  // add carry becomes the new top bit as the whole pair shifts right.
  always_comb begin
    sum      = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, mcand_i} : '0);
    mul_next = {sum, acc_i[WIDTH-1:1]};
  end

  // Divide: acc = {remainder, dividend/quotient}. The next dividend bit moves
  // into the remainder; diff[WIDTH] is the borrow that says "restore".
  always_comb begin
    shifted = acc_i[2*WIDTH-1:WIDTH-1];
    diff    = shifted - {1'b0, divisor_i};
    if (diff[WIDTH]) begin
      div_next = {shifted[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
    end else begin
      div_next = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
    end
  end

  assign acc_o = div_i ? div_next : mul_next;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle unsigned MULTU/DIVU unit owning the architectural HI/LO pair.
// Results iterate in shadow state and land in HI/LO only on the final step.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = MD_CNT_W  // 2**CNT_W must exceed WIDTH
) (
  input  logic    clk,
  input  logic    rst,
  muldiv_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               accept;
  logic               iterating;
  logic               last_step;
  logic [2*WIDTH-1:0] step_acc;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = (bus.muldiv_ctrl == MD_DIVU) ? ST_DIV : ST_MUL;
        end
      end
      ST_MUL, ST_DIV: begin
        if (last_step) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    iterating = (state_q == ST_MUL) || (state_q == ST_DIV);
    accept    = (state_q == ST_IDLE) && bus.we_muldiv && md_op_valid(bus.muldiv_ctrl);
    last_step = iterating && (cnt_q == CNT_LAST);
  end

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .div_i    (state_q == ST_DIV),
    .acc_i    (acc_q),
    .mcand_i  (a_q),
    .divisor_i(b_q),
    .acc_o    (step_acc)
  );

  // Datapath next values; HI/LO are touched only on the last iteration.
  always_comb begin
    cnt_d  = cnt_q;
    a_d    = a_q;
    b_d    = b_q;
    acc_d  = acc_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = 1'b0;
    if (accept) begin
      cnt_d = CNT_INIT;
      a_d   = bus.a;
      b_d   = bus.b;
      acc_d = (bus.muldiv_ctrl == MD_DIVU) ? {{WIDTH{1'b0}}, bus.a} : {{WIDTH{1'b0}}, bus.b};
    end else if (iterating) begin
      cnt_d = cnt_q - CNT_LAST;
      acc_d = step_acc;
      if (last_step) begin
        hi_d   = step_acc[2*WIDTH-1:WIDTH];
        lo_d   = step_acc[WIDTH-1:0];
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      a_q    <= a_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= done_d;
    end
  end

  assign bus.hilo_rd = bus.hilo_stream ? hi_q : lo_q;
  assign bus.busy    = iterating;
  assign bus.done    = done_q;
  assign bus.state   = state_q;

endmodule
